// File: rtl/multivoice_chorus_core.sv
`default_nettype none
//============================================================================
// Module   : multivoice_chorus_core
// Brief    : Multi-voice chorus. One circular delay buffer read by NUM_VOICES
//            LFO-offset taps; the taps are averaged into a wet sample and
//            blended with the dry sample under a mix control, with saturation.
// Config   : CHORUS_FEEDBACK_EN - when defined, voice 0 of the previous sample
//            is fed back (>>>2) into the written sample.
// Revision : 1.0 - initial release
//============================================================================
module multivoice_chorus_core #(
    parameter int PKT_WIDTH  = 16,
    parameter int NUM_VOICES = 2,
    parameter int BUF_DEPTH  = 4410,
    parameter int AVG_DELAY  = 882,
    parameter int MIX_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [PKT_WIDTH-1:0]            pkt_i,
    input  logic                            pktChanged_i,
    input  logic [NUM_VOICES*PKT_WIDTH-1:0] delay_i,
    input  logic [MIX_WIDTH-1:0]            mix_i,
    output logic [PKT_WIDTH-1:0]            pktMixed_o,
    output logic                            pktMixedChanged_o,
    output logic                            busy_o,
    output logic                            errorLED_o
);

    localparam int AW    = $clog2(BUF_DEPTH);
    localparam int FW    = $clog2(BUF_DEPTH + 1);
    localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int SHIFT = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 0;
    localparam int ACCW  = PKT_WIDTH + 3;
    localparam int PW    = PKT_WIDTH + MIX_WIDTH + 2;
    localparam logic signed [PW-1:0] PMAX = PW'((2 ** (PKT_WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] PMIN = PW'(-(2 ** (PKT_WIDTH - 1)));
    localparam logic [MIX_WIDTH:0]   WFULL = (MIX_WIDTH + 1)'(2 ** MIX_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_ACC, S_MIX} state_t;

    state_t                        r_state, w_next;
    logic signed [PKT_WIDTH-1:0]   r_dry;
    logic [NUM_VOICES*PKT_WIDTH-1:0] r_delay;
    logic [MIX_WIDTH-1:0]          r_mix;
    logic [AW-1:0]                 r_wr_ptr, r_wr_addr;
    logic [FW-1:0]                 r_fill;
    logic [VW-1:0]                 r_voice;
    logic signed [ACCW-1:0]        r_acc;
    logic                          r_tap_ok, r_tap_is0;
    logic signed [PKT_WIDTH-1:0]   r_rd_data;
    logic [PKT_WIDTH-1:0]          r_out;
    logic                          r_strobe, r_err;
    logic [PKT_WIDTH-1:0]          r_mem [BUF_DEPTH];

    logic                          w_last_voice;
    logic signed [PKT_WIDTH-1:0]   w_off, w_tap, w_wr_data, w_wet, w_out;
    logic signed [31:0]            w_d_raw;
    logic [AW-1:0]                 w_d, w_rd_addr;
    logic                          w_tap_ok;
    logic signed [ACCW-1:0]        w_acc_fin;
    logic [MIX_WIDTH:0]            w_wt, w_inv;
    logic signed [PW-1:0]          w_mix_sum;

    // Clamp a wide signed value into the sample range.
    function automatic logic signed [PKT_WIDTH-1:0] sat(input logic signed [PW-1:0] v);
        if (v > PMAX)      return PMAX[PKT_WIDTH-1:0];
        else if (v < PMIN) return PMIN[PKT_WIDTH-1:0];
        else               return v[PKT_WIDTH-1:0];
    endfunction

    assign w_last_voice = (r_voice == VW'(NUM_VOICES - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; only IDLE accepts a new sample.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (pktChanged_i) w_next = S_WRITE;
            S_WRITE: w_next = S_READ;
            S_READ:  if (w_last_voice) w_next = S_ACC;
            S_ACC:   w_next = S_MIX;
            S_MIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Tap delay clamp, wrap-safe address and fill gating for the current voice.
    always_comb begin
        w_off   = $signed(r_delay[r_voice*PKT_WIDTH +: PKT_WIDTH]);
        w_d_raw = AVG_DELAY + 32'(w_off);
        if (w_d_raw < 1)                   w_d = AW'(1);
        else if (w_d_raw > BUF_DEPTH - 1)  w_d = AW'(BUF_DEPTH - 1);
        else                               w_d = w_d_raw[AW-1:0];
        if (r_wr_addr >= w_d) w_rd_addr = r_wr_addr - w_d;
        else                  w_rd_addr = r_wr_addr + (AW'(BUF_DEPTH) - w_d);
        // The current sample occupies one fill slot, so only older samples count.
        w_tap_ok = (FW'(w_d) < r_fill);
    end

    // Wet average and wet/dry blend, evaluated while the last tap arrives.
    always_comb begin
        w_tap     = r_tap_ok ? r_rd_data : '0;
        w_acc_fin = r_acc + ACCW'(w_tap);
        w_wet     = sat(PW'(w_acc_fin) >>> SHIFT);
        w_wt      = (&r_mix) ? WFULL : {1'b0, r_mix};
        w_inv     = WFULL - w_wt;
        w_mix_sum = PW'(r_dry) * $signed(PW'(w_inv)) + PW'(w_wet) * $signed(PW'(w_wt));
        w_out     = sat(w_mix_sum >>> MIX_WIDTH);
    end

`ifdef CHORUS_FEEDBACK_EN
    logic signed [PKT_WIDTH-1:0] r_fb;

    // Hold voice 0 of the previous sample for feedback into the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fb <= '0;
        else if (r_tap_is0 && (r_state == S_READ || r_state == S_ACC)) r_fb <= w_tap;
    end

    assign w_wr_data = sat(PW'(r_dry) + (PW'(r_fb) >>> 2));
`else
    assign w_wr_data = r_dry;
`endif

    // Delay RAM: one write per sample, synchronous read one tap per cycle.
    always_ff @(posedge clk) begin
        if (r_state == S_WRITE) r_mem[r_wr_ptr] <= w_wr_data;
        r_rd_data <= $signed(r_mem[w_rd_addr]);
    end

    // Sample datapath: latch, pointer/fill update, accumulate, output and overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dry     <= '0;
            r_delay   <= '0;
            r_mix     <= '0;
            r_wr_ptr  <= '0;
            r_wr_addr <= '0;
            r_fill    <= '0;
            r_voice   <= '0;
            r_acc     <= '0;
            r_tap_ok  <= 1'b0;
            r_tap_is0 <= 1'b0;
            r_out     <= '0;
            r_strobe  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_strobe  <= 1'b0;
            r_tap_is0 <= 1'b0;
            if (pktChanged_i && r_state != S_IDLE) r_err <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (pktChanged_i) begin
                        r_dry   <= $signed(pkt_i);
                        r_delay <= delay_i;
                        r_mix   <= mix_i;
                        r_acc   <= '0;
                    end
                end
                S_WRITE: begin
                    r_wr_addr <= r_wr_ptr;
                    r_wr_ptr  <= (r_wr_ptr == AW'(BUF_DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
                    if (r_fill != FW'(BUF_DEPTH)) r_fill <= r_fill + FW'(1);
                    r_voice   <= '0;
                end
                S_READ: begin
                    r_tap_ok  <= w_tap_ok;
                    r_tap_is0 <= (r_voice == '0);
                    if (!w_last_voice) r_voice <= r_voice + VW'(1);
                    if (r_voice != '0) r_acc <= w_acc_fin;
                end
                S_ACC: begin
                    r_acc    <= w_acc_fin;
                    r_out    <= w_out;
                    r_strobe <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pktMixed_o        = r_out;
    assign pktMixedChanged_o = r_strobe;
    assign busy_o            = (r_state != S_IDLE);
    assign errorLED_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_multivoice_chorus_core.sv
`default_nettype none
//============================================================================
// Module   : tb_multivoice_chorus_core
// Brief    : Scoreboard bench for multivoice_chorus_core (default build).
// Revision : 1.0 - initial release
//============================================================================
module tb_multivoice_chorus_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pkt_i = '0;
    logic        pktChanged_i = 1'b0;
    logic [31:0] delay_i = '0;
    logic [3:0]  mix_i = '0;
    logic [15:0] pktMixed_o;
    logic        pktMixedChanged_o;
    logic        busy_o;
    logic        errorLED_o;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [15:0] exp_q [$];
    int          cyc_q [$];

    multivoice_chorus_core dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pkt_i             (pkt_i),
        .pktChanged_i      (pktChanged_i),
        .delay_i           (delay_i),
        .mix_i             (mix_i),
        .pktMixed_o        (pktMixed_o),
        .pktMixedChanged_o (pktMixedChanged_o),
        .busy_o            (busy_o),
        .errorLED_o        (errorLED_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: pops one expectation per output strobe, checks value and latency.
    always @(negedge clk) begin
        if (rst_n && pktMixedChanged_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got value %0h at cycle %0d expected no strobe",
                         pktMixed_o, cyc);
            end else begin
                logic [15:0] ev;
                int          ec;
                ev = exp_q.pop_front();
                ec = cyc_q.pop_front();
                chk("out_value", 32'(pktMixed_o), 32'(ev));
                chk("out_latency", 32'(cyc), 32'(ec));
            end
        end
    end

    // Issue one sample; optionally schedule its expected output 5 cycles later.
    task automatic send(input logic [15:0] pkt, input logic [15:0] o0, input logic [15:0] o1,
                        input logic [3:0] mix, input bit has_exp, input logic [15:0] expv);
        @(negedge clk);
        pkt_i        = pkt;
        delay_i      = {o1, o0};
        mix_i        = mix;
        pktChanged_i = 1'b1;
        if (has_exp) begin
            exp_q.push_back(expv);
            cyc_q.push_back(cyc + 5);
        end
        @(negedge clk);
        pktChanged_i = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [15:0] neg900;
        int          t0, t1;
        neg900 = 16'hFC7C;  // -900

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pktMixed", 32'(pktMixed_o), 0);
        chk("rst_strobe", 32'(pktMixedChanged_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_error", 32'(errorLED_o), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Dry path
        send(16'h4000, 16'h0, 16'h0, 4'h0, 1'b1, 16'h4000);
        send(16'h8000, 16'h0, 16'h0, 4'h0, 1'b1, 16'h8000);
        send(16'h1234, 16'h0, 16'h0, 4'h0, 1'b1, 16'h1234);

        // Reset mid-READ: outputs drop at once, no strobe follows
        @(negedge clk);
        pkt_i = 16'h2222; mix_i = 4'h0; pktChanged_i = 1'b1;
        @(negedge clk);
        pktChanged_i = 1'b0;
        chk("busy_after_accept", 32'(busy_o), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_pktMixed", 32'(pktMixed_o), 0);
        chk("midrst_busy", 32'(busy_o), 0);
        chk("midrst_strobe", 32'(pktMixedChanged_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        send(16'h0321, 16'h0, 16'h0, 4'h0, 1'b1, 16'h0321);

        // Wet path: impulse appears only at sample 882
        do_reset();
        for (int n = 0; n < 885; n++)
            send((n == 0) ? 16'h4000 : 16'h0, 16'h0, 16'h0, 4'hF, 1'b1,
                 (n == 882) ? 16'h4000 : 16'h0);

        // Clamp and fill: voice0 d=1 (previous sample), voice1 d=882
        do_reset();
        for (int n = 0; n < 885; n++) begin
            t0 = (n >= 1) ? n : 0;
            t1 = (n >= 882) ? n - 881 : 0;
            send(16'(n + 1), neg900, 16'h0, 4'hF, 1'b1, 16'((t0 + t1) >> 1));
        end

        // Saturation and half mix, wet = previous sample on both voices
        do_reset();
        send(16'h7FFF, neg900, neg900, 4'h8, 1'b1, 16'h3FFF);
        send(16'h7FFF, neg900, neg900, 4'h8, 1'b1, 16'h7FFF);
        send(16'h8000, neg900, neg900, 4'h8, 1'b1, 16'hFFFF);
        send(16'h8000, neg900, neg900, 4'h8, 1'b1, 16'h8000);
        send(16'h1000, neg900, neg900, 4'h8, 1'b1, 16'hC800);

        // Overrun: second strobe two cycles after the first is dropped
        chk("no_error_before_overrun", 32'(errorLED_o), 0);
        @(negedge clk);
        pkt_i = 16'h0555; delay_i = '0; mix_i = 4'h0; pktChanged_i = 1'b1;
        exp_q.push_back(16'h0555);
        cyc_q.push_back(cyc + 5);
        @(negedge clk);
        pktChanged_i = 1'b0;
        @(negedge clk);
        pkt_i = 16'h7777; pktChanged_i = 1'b1;
        @(negedge clk);
        pktChanged_i = 1'b0;
        repeat (12) @(negedge clk);
        chk("overrun_error", 32'(errorLED_o), 1);
        send(16'h0100, 16'h0, 16'h0, 4'h0, 1'b1, 16'h0100);
        chk("error_sticky", 32'(errorLED_o), 1);
        do_reset();
        chk("error_cleared", 32'(errorLED_o), 0);

        // Drain the scoreboard within a bounded wait
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
